// File: rtl/queue_pkg.sv
// queue_pkg: shared constants and types for the byte FIFO.
//   WIDTH  - data word width in bits
//   DEPTH  - number of storage entries (power of two)
//   LEN_W  - width of the occupancy count, wide enough to hold DEPTH
//   word_t - one stored data word
package queue_pkg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;
  localparam int LEN_W = $clog2(DEPTH + 1);

  typedef logic [WIDTH-1:0] word_t;

endpackage : queue_pkg

// File: rtl/queue_mem.sv
// queue_mem: storage array for the FIFO. It has one synchronous write port and
// one asynchronous read port. The array has no reset because its contents are
// only meaningful once a write has occurred.
//   clk      - write clock
//   wr_en    - write strobe
//   wr_addr  - write index
//   wr_data  - word to store
//   rd_addr  - read index
//   rd_data  - word currently held at rd_addr
module queue_mem #(
  parameter int WIDTH = queue_pkg::WIDTH,
  parameter int DEPTH = queue_pkg::DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule : queue_mem

// File: rtl/queue.sv
// queue: synchronous FIFO, DEPTH entries of WIDTH bits.
//   clk_10khz  - system clock; all state changes on its rising edge
//   reset      - asynchronous active-low reset
//   data_in    - word written when enqueue_in is sampled high
//   enqueue_in - push request, one push per cycle while high
//   dequeue_in - pop request, one pop per cycle while high
//   ack_in     - registered pulse: an operation was accepted at the last edge
//   len_out    - number of valid entries (0..DEPTH), taken straight from a register
//   data_out   - registered word most recently popped
module queue #(
  parameter int WIDTH = queue_pkg::WIDTH,
  parameter int DEPTH = queue_pkg::DEPTH,
  parameter int LEN_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_10khz,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enqueue_in,
  input  logic             dequeue_in,
  output logic             ack_in,
  output logic [LEN_W-1:0] len_out,
  output logic [WIDTH-1:0] data_out
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             ack_q, ack_d;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic [WIDTH-1:0] rd_data_s;

  queue_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk     (clk_10khz),
    .wr_en   (push_ok_s),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data_s)
  );

  // Acceptance decisions. When the queue is full, a push is still accepted if
  // a pop is accepted in the same cycle. The head is read out before the edge
  // and the freed slot is then the one at wr_ptr, so no word is overwritten.
  always_comb begin
    pop_ok_s  = 1'b0;
    push_ok_s = 1'b0;
    if (dequeue_in && (count_q != {LEN_W{1'b0}})) begin
      pop_ok_s = 1'b1;
    end else begin
      pop_ok_s = 1'b0;
    end
    if (enqueue_in && ((count_q != LEN_W'(DEPTH)) || pop_ok_s)) begin
      push_ok_s = 1'b1;
    end else begin
      push_ok_s = 1'b0;
    end
  end

  // Next-state computation for the pointers, the count and the outputs.
  // Pointer increments wrap naturally because DEPTH is a power of two.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    ack_d      = push_ok_s | pop_ok_s;

    if (pop_ok_s) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = rd_data_s;
    end else begin
      rd_ptr_d   = rd_ptr_q;
      data_out_d = data_out_q;
    end

    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + LEN_W'(1);
      2'b01:   count_d = count_q - LEN_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset is asynchronous and active low.
  always_ff @(posedge clk_10khz or negedge reset) begin
    if (!reset) begin
      rd_ptr_q   <= {PTR_W{1'b0}};
      wr_ptr_q   <= {PTR_W{1'b0}};
      count_q    <= {LEN_W{1'b0}};
      data_out_q <= {WIDTH{1'b0}};
      ack_q      <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      ack_q      <= ack_d;
    end
  end

  assign ack_in   = ack_q;
  assign len_out  = count_q;
  assign data_out = data_out_q;

endmodule : queue

// File: tb/tb_queue.sv
`timescale 1us/1ns
module tb_queue;
  import queue_pkg::*;

  logic             clk_10khz;
  logic             reset;
  word_t            data_in;
  logic             enqueue_in;
  logic             dequeue_in;
  logic             ack_in;
  logic [LEN_W-1:0] len_out;
  word_t            data_out;

  int err_cnt;
  int chk_cnt;

  // The FIFO contents model and the scoreboard of expected popped words.
  word_t model_q[$];
  word_t exp_q[$];
  word_t held_data;

  queue dut (
    .clk_10khz  (clk_10khz),
    .reset      (reset),
    .data_in    (data_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .ack_in     (ack_in),
    .len_out    (len_out),
    .data_out   (data_out)
  );

  // 10 kHz clock: a 100 us period.
  initial clk_10khz = 1'b0;
  always #50 clk_10khz = ~clk_10khz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of requests and update the model. Then, after the edge,
  // check ack, length and the popped word taken from the scoreboard.
  task automatic step(input logic en, input logic de, input word_t din, input string tag);
    bit pop_ok;
    bit push_ok;
    @(negedge clk_10khz);
    enqueue_in = en;
    dequeue_in = de;
    data_in    = din;
    pop_ok  = de && (model_q.size() > 0);
    push_ok = en && ((model_q.size() < DEPTH) || pop_ok);
    if (pop_ok) exp_q.push_back(model_q.pop_front());
    if (push_ok) model_q.push_back(din);
    @(posedge clk_10khz);
    #1;
    check({tag, ".ack"}, 32'(ack_in), 32'(push_ok | pop_ok));
    check({tag, ".len"}, 32'(len_out), 32'(model_q.size()));
    if (exp_q.size() > 0) held_data = exp_q.pop_front();
    check({tag, ".data"}, 32'(data_out), 32'(held_data));
  endtask

  initial begin
    err_cnt    = 0;
    chk_cnt    = 0;
    held_data  = 8'h00;
    reset      = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    data_in    = 8'h00;

    #20;
    check("rst.len", 32'(len_out), 32'd0);
    check("rst.data", 32'(data_out), 32'h00);
    check("rst.ack", 32'(ack_in), 32'd0);
    @(negedge clk_10khz);
    reset = 1'b1;

    step(1'b0, 1'b0, 8'h00, "idle");

    // Fill: A5 followed by 02..08.
    step(1'b1, 1'b0, 8'hA5, "fill");
    for (int i = 2; i <= 8; i++) step(1'b1, 1'b0, 8'(i), "fill");

    // Overflow is ignored, and FF must never appear at the output.
    step(1'b1, 1'b0, 8'hFF, "ovf");

    step(1'b0, 1'b1, 8'h00, "pop1");
    step(1'b1, 1'b1, 8'h77, "pushpop");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 8'h00, "drain");

    // Underflow: data_out holds 77 and ack stays low.
    step(1'b0, 1'b1, 8'h00, "udf");
    // Both requests on an empty queue: the push is accepted, data_out holds.
    step(1'b1, 1'b1, 8'h3C, "emptyboth");
    // Both requests on a full queue.
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h40 + i), "refill");
    step(1'b1, 1'b1, 8'h99, "fullboth");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, "drain2");

    // Mixed traffic across the pointer wrap.
    for (int i = 0; i < 24; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), "wrap");
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, 8'(8'hC0 + i), "stream");

    // Reset in mid-stream, asserted between edges.
    step(1'b1, 1'b0, 8'h11, "pre_rst");
    step(1'b0, 1'b1, 8'h00, "pre_rst");
    #10;
    reset = 1'b0;
    #1;
    check("midrst.len", 32'(len_out), 32'd0);
    check("midrst.data", 32'(data_out), 32'h00);
    check("midrst.ack", 32'(ack_in), 32'd0);
    model_q.delete();
    exp_q.delete();
    held_data = 8'h00;
    @(negedge clk_10khz);
    reset = 1'b1;
    step(1'b0, 1'b1, 8'h00, "post_rst_udf");
    step(1'b1, 1'b0, 8'h5A, "post_rst");
    step(1'b0, 1'b1, 8'h00, "post_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule : tb_queue

// File: doc/queue.md
Name: queue

Overview:
- Synchronous FIFO, 8 entries deep and 8 bits wide, in the single 10 kHz clock domain.
- Producer logic pushes bytes with enqueue_in; consumer logic pops them with dequeue_in.
- Reports current occupancy on len_out, presents the most recently popped byte on data_out, and pulses ack_in after every accepted operation.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two.
- LEN_W, $clog2(DEPTH+1) = 4, width of the occupancy count.

Ports:
- clk_10khz  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  WIDTH  word to write when enqueue_in is sampled high.
- enqueue_in  input  1  level-sensitive push request; one push per clock while high.
- dequeue_in  input  1  level-sensitive pop request; one pop per clock while high.
- ack_in  output  1  registered one-cycle acknowledge of the operation accepted at the previous edge.
- len_out  output  LEN_W  number of valid entries, 0..DEPTH.
- data_out  output  WIDTH  registered word most recently popped.

Behaviour:
- Reset (reset = 0, asynchronous): read pointer, write pointer and count clear to 0; len_out = 0, data_out = 0, ack_in = 0. Storage contents are don't-care.
- Requests are sampled on each rising edge of clk_10khz. A request held high for N cycles is treated as N requests.
- Push accepted when enqueue_in = 1 and (count < DEPTH, or a pop is also accepted in the same cycle):
  - mem[wr_ptr] <= data_in;
  - wr_ptr increments modulo DEPTH.
- Pop accepted when dequeue_in = 1 and count > 0:
  - data_out <= mem[rd_ptr], where rd_ptr is the value before the edge;
  - rd_ptr increments modulo DEPTH;
  - the new data_out is visible one edge after the request is sampled.
- Count update:
  - push only: +1;
  - pop only: -1;
  - both accepted: unchanged;
  - neither accepted: unchanged.
- Full (count = DEPTH): push alone is ignored; storage, pointers and len_out are unchanged; no error flag.
- Empty (count = 0): pop is ignored and data_out holds its previous value.
- Empty with both requests: push only; count becomes 1 and data_out holds.
- Full with both requests: both accepted. The pop reads the old head; the push writes into the freed slot (wr_ptr == rd_ptr); count stays DEPTH.
- Ordering is strict FIFO. Pointers wrap naturally at DEPTH-1 -> 0.
- ack_in <= (push accepted) OR (pop accepted), registered. It is low after any cycle with no accepted operation, including ignored overflow and underflow requests.
- len_out is driven directly from the count register, with no combinational path from the inputs.
- Reset asserted mid-operation clears all state immediately; the queue is empty when reset deasserts.

Decomposition:
- Package queue_pkg: WIDTH, DEPTH, LEN_W default constants and a word_t typedef (logic [WIDTH-1:0]).
- No sub-module required. Storage array, two pointers and the count live in one module.
- The storage may optionally be split out as a simple register-file sub-module named queue_mem (one write port, one read port, no reset).

Test Plan:
- Reset then idle -> len_out = 0, data_out = 00, ack_in = 0.
- Push A5 for one cycle, then pushes of 02..08, one per cycle with enqueue_in held -> len_out steps 1..8 after each edge; ack_in high each following cycle.
- At full, push FF -> len_out stays 8, ack_in = 0, and FF is never dequeued later.
- Single pop -> data_out = A5, len_out = 7.
- Simultaneous push 77 + pop with count 7 -> data_out = 02, len_out = 7. Continuing pops yield 03..08 then 77, then len_out = 0.
- Underflow and wrap: pop on empty -> data_out unchanged, ack_in = 0. Then 20 push/pop cycles across the pointer wrap -> order preserved. Drive reset low mid-stream -> len_out = 0 and data_out = 00 immediately.
